// File: rtl/router_pkg.sv
// Shared constants and address decode helper for the router synchroniser.
package router_pkg;

  localparam int ADDR_W          = 2;
  localparam int NUM_PORTS       = 3;
  localparam int TIMEOUT_DEFAULT = 30;
  localparam int CNT_W           = 5;

  typedef logic [ADDR_W-1:0]    addr_t;
  typedef logic [NUM_PORTS-1:0] port_vec_t;

  localparam addr_t ADDR_P0  = 2'b00;
  localparam addr_t ADDR_P1  = 2'b01;
  localparam addr_t ADDR_P2  = 2'b10;
  // 11 is never a legal destination; it is also the idle/reset address.
  localparam addr_t ADDR_INV = 2'b11;

  function automatic port_vec_t decode_addr(input addr_t addr);
    port_vec_t oh;
    case (addr)
      ADDR_P0: oh = 3'b001;
      ADDR_P1: oh = 3'b010;
      ADDR_P2: oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-FIFO unread-valid timeout; pulses soft_reset once per TIMEOUT_CYCLES stalled edges.
// Counter is only built when ROUTER_SYNC_SOFT_RESET_EN is defined; otherwise soft_reset is 0.
module router_sync_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic read_enb,
  output logic soft_reset
);

`ifdef ROUTER_SYNC_SOFT_RESET_EN
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pulse_q;
  logic             pulse_d;

  // Next count and pulse; a read in the terminal cycle wins over the pulse.
  always_comb begin
    cnt_d   = {CNT_W{1'b0}};
    pulse_d = 1'b0;
    if (!vld || read_enb) begin
      cnt_d   = {CNT_W{1'b0}};
      pulse_d = 1'b0;
    end else if (cnt_q == LAST_CNT) begin
      cnt_d   = {CNT_W{1'b0}};
      pulse_d = 1'b1;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
      pulse_d = 1'b0;
    end
  end

  // Counter and registered pulse.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      cnt_q   <= {CNT_W{1'b0}};
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign soft_reset = pulse_q;
`else
  logic unused_s;
  assign unused_s   = ^{clock, resetn, vld, read_enb};
  assign soft_reset = 1'b0;
`endif

endmodule

// File: rtl/router_sync.sv
// Router synchroniser: latches the destination address, steers write enables,
// reports the addressed FIFO's full flag and generates per-FIFO timeout resets
// (timeouts active only with ROUTER_SYNC_SOFT_RESET_EN defined).
module router_sync
  import router_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 detect_add,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 write_enb_reg,
  input  logic                 read_enb_0,
  input  logic                 read_enb_1,
  input  logic                 read_enb_2,
  input  logic                 empty_0,
  input  logic                 empty_1,
  input  logic                 empty_2,
  input  logic                 full_0,
  input  logic                 full_1,
  input  logic                 full_2,
  output logic                 vld_out_0,
  output logic                 vld_out_1,
  output logic                 vld_out_2,
  output logic                 soft_reset_0,
  output logic                 soft_reset_1,
  output logic                 soft_reset_2,
  output logic                 fifo_full,
  output logic [NUM_PORTS-1:0] write_enb
);

  addr_t     addr_q;
  addr_t     addr_d;
  port_vec_t rd_s;
  port_vec_t empty_s;
  port_vec_t full_s;
  port_vec_t vld_s;
  port_vec_t sr_s;
  port_vec_t write_enb_s;
  logic      fifo_full_s;

  assign rd_s    = {read_enb_2, read_enb_1, read_enb_0};
  assign empty_s = {empty_2, empty_1, empty_0};
  assign full_s  = {full_2, full_1, full_0};
  assign vld_s   = ~empty_s;

  // Address capture on header strobe.
  always_comb begin
    addr_d = addr_q;
    if (detect_add) begin
      addr_d = data_in;
    end else begin
      addr_d = addr_q;
    end
  end

  // Address register; resets to the invalid address so nothing is enabled.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      addr_q <= ADDR_INV;
    end else begin
      addr_q <= addr_d;
    end
  end

  // Write steering decodes the stored address, so a same-cycle header still uses the old one.
  always_comb begin
    write_enb_s = 3'b000;
    if (write_enb_reg) begin
      write_enb_s = decode_addr(addr_q);
    end else begin
      write_enb_s = 3'b000;
    end
  end

  // Full flag of the currently addressed FIFO.
  always_comb begin
    fifo_full_s = 1'b0;
    case (addr_q)
      ADDR_P0: fifo_full_s = full_s[0];
      ADDR_P1: fifo_full_s = full_s[1];
      ADDR_P2: fifo_full_s = full_s[2];
      default: fifo_full_s = 1'b0;
    endcase
  end

  for (genvar n = 0; n < NUM_PORTS; n++) begin : g_timer
    router_sync_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
      .clock     (clock),
      .resetn    (resetn),
      .vld       (vld_s[n]),
      .read_enb  (rd_s[n]),
      .soft_reset(sr_s[n])
    );
  end

  assign write_enb    = write_enb_s;
  assign fifo_full    = fifo_full_s;
  assign vld_out_0    = vld_s[0];
  assign vld_out_1    = vld_s[1];
  assign vld_out_2    = vld_s[2];
  assign soft_reset_0 = sr_s[0];
  assign soft_reset_1 = sr_s[1];
  assign soft_reset_2 = sr_s[2];

endmodule

// File: tb/tb_router_sync.sv
// Scoreboard bench for router_sync: combinational outputs via a pushed expectation
// queue, timeout pulses via expected/observed pulse-cycle queues.
module tb_router_sync;

  logic       clock;
  logic       resetn;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       fifo_full;
  logic [2:0] write_enb;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef enum {K_WE, K_FULL, K_VLD, K_SR} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  exp_p0[$];
  int  obs_p0[$];
  int  obs_p1[$];
  int  obs_p2[$];

  router_sync dut (
    .clock        (clock),
    .resetn       (resetn),
    .detect_add   (detect_add),
    .data_in      (data_in),
    .write_enb_reg(write_enb_reg),
    .read_enb_0   (read_enb_0),
    .read_enb_1   (read_enb_1),
    .read_enb_2   (read_enb_2),
    .empty_0      (empty_0),
    .empty_1      (empty_1),
    .empty_2      (empty_2),
    .full_0       (full_0),
    .full_1       (full_1),
    .full_2       (full_2),
    .vld_out_0    (vld_out_0),
    .vld_out_1    (vld_out_1),
    .vld_out_2    (vld_out_2),
    .soft_reset_0 (soft_reset_0),
    .soft_reset_1 (soft_reset_1),
    .soft_reset_2 (soft_reset_2),
    .fifo_full    (fifo_full),
    .write_enb    (write_enb)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (soft_reset_0) obs_p0.push_back(cyc);
    if (soft_reset_1) obs_p1.push_back(cyc);
    if (soft_reset_2) obs_p2.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input kind_e kind, input logic [31:0] exp);
    sb_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic compare_out();
    sb_t         e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_WE:    obs = {29'd0, write_enb};
        K_FULL:  obs = {31'd0, fifo_full};
        K_VLD:   obs = {29'd0, vld_out_2, vld_out_1, vld_out_0};
        default: obs = {29'd0, soft_reset_2, soft_reset_1, soft_reset_0};
      endcase
      check_eq(e.tag, obs, e.exp);
    end
  endtask

  task automatic drive();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
    compare_out();
  endtask

  task automatic check_pulses(input string tag);
    int n_exp;
    int n_obs;
    n_exp = exp_p0.size();
    n_obs = obs_p0.size();
    check_eq({tag, "_sr0_count"}, n_obs, n_exp);
    while (exp_p0.size() > 0 && obs_p0.size() > 0)
      check_eq({tag, "_sr0_cycle"}, obs_p0.pop_front(), exp_p0.pop_front());
    check_eq({tag, "_sr1_count"}, obs_p1.size(), 32'd0);
    check_eq({tag, "_sr2_count"}, obs_p2.size(), 32'd0);
    exp_p0.delete();
    obs_p0.delete();
    obs_p1.delete();
    obs_p2.delete();
  endtask

  task automatic set_addr(input logic [1:0] a);
    drive();
    detect_add = 1'b1;
    data_in    = a;
    drive();
    detect_add = 1'b0;
  endtask

  initial begin : stim
    int          s;
    logic [2:0]  fpat [7];
    logic [1:0]  fadr [7];
    logic        fexp [7];
    logic [2:0]  vpat [4];
    logic [1:0]  a;

    resetn        = 1'b1;
    detect_add    = 1'b0;
    data_in       = 2'b00;
    write_enb_reg = 1'b1;
    {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
    {empty_2, empty_1, empty_0}          = 3'b010;
    {full_2, full_1, full_0}             = 3'b111;

    // reset state
    drive();
    drive();
    expect_out("rst_we", K_WE, 32'd0);
    expect_out("rst_full", K_FULL, 32'd0);
    expect_out("rst_vld", K_VLD, 32'h5);
    expect_out("rst_sr", K_SR, 32'd0);
    sample();

    drive();
    resetn        = 1'b0;
    write_enb_reg = 1'b0;
    {empty_2, empty_1, empty_0} = 3'b111;
    {full_2, full_1, full_0}    = 3'b000;

    // address decode
    for (int i = 0; i < 4; i++) begin
      a = 2'(i);
      set_addr(a);
      write_enb_reg = 1'b0;
      expect_out("we_reg0", K_WE, 32'd0);
      sample();
      drive();
      write_enb_reg = 1'b1;
      expect_out($sformatf("we_addr%0d", i), K_WE, (i == 3) ? 32'd0 : (32'd1 << i));
      sample();
    end

    // header and write in the same cycle: old address applies until the edge
    set_addr(2'b10);
    drive();
    detect_add    = 1'b1;
    data_in       = 2'b00;
    write_enb_reg = 1'b1;
    expect_out("we_same_old", K_WE, 32'h4);
    sample();
    drive();
    detect_add = 1'b0;
    expect_out("we_same_new", K_WE, 32'h1);
    sample();

    // fifo_full selection
    fadr = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
    fpat = '{3'b001, 3'b110, 3'b101, 3'b010, 3'b100, 3'b011, 3'b111};
    fexp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      set_addr(fadr[i]);
      {full_2, full_1, full_0} = fpat[i];
      expect_out($sformatf("full_%0d", i), K_FULL, {31'd0, fexp[i]});
      sample();
    end
    {full_2, full_1, full_0} = 3'b000;

    // vld_out follows ~empty
    vpat = '{3'b000, 3'b011, 3'b101, 3'b110};
    for (int i = 0; i < 4; i++) begin
      drive();
      {empty_2, empty_1, empty_0} = vpat[i];
      expect_out($sformatf("vld_%0d", i), K_VLD, {29'd0, ~vpat[i]});
      sample();
    end
    drive();
    {empty_2, empty_1, empty_0} = 3'b111;
    drive();
    check_pulses("pre");

    // continuous stall on port 0; port 1 valid but always read
    set_addr(2'b00);
    {empty_2, empty_1, empty_0}          = 3'b100;
    {read_enb_2, read_enb_1, read_enb_0} = 3'b010;
    s = cyc;
`ifdef ROUTER_SYNC_SOFT_RESET_EN
    exp_p0.push_back(s + 30);
    exp_p0.push_back(s + 60);
`endif
    repeat (65) drive();
    {empty_2, empty_1, empty_0}          = 3'b111;
    {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
    drive();
    check_pulses("stall");

    // read after 20 cycles restarts the count; read in terminal cycle suppresses
    {empty_2, empty_1, empty_0} = 3'b110;
    s = cyc;
    repeat (20) drive();
    read_enb_0 = 1'b1;
    drive();
    read_enb_0 = 1'b0;
`ifdef ROUTER_SYNC_SOFT_RESET_EN
    exp_p0.push_back(s + 51);
`endif
    repeat (59) drive();
    read_enb_0 = 1'b1;
    drive();
    read_enb_0 = 1'b0;
    {empty_2, empty_1, empty_0} = 3'b111;
    drive();
    drive();
    check_pulses("read");

    // valid drops mid-count
    {empty_2, empty_1, empty_0} = 3'b110;
    s = cyc;
    repeat (15) drive();
    empty_0 = 1'b1;
    drive();
    empty_0 = 1'b0;
`ifdef ROUTER_SYNC_SOFT_RESET_EN
    exp_p0.push_back(s + 46);
`endif
    repeat (32) drive();
    {empty_2, empty_1, empty_0} = 3'b111;
    drive();
    check_pulses("empty");

    // reset at count 15
    {empty_2, empty_1, empty_0} = 3'b110;
    write_enb_reg = 1'b1;
    {full_2, full_1, full_0} = 3'b111;
    s = cyc;
    repeat (15) drive();
    resetn = 1'b1;
    expect_out("mid_rst_we", K_WE, 32'd0);
    expect_out("mid_rst_full", K_FULL, 32'd0);
    expect_out("mid_rst_sr", K_SR, 32'd0);
    sample();
    drive();
    resetn = 1'b0;
`ifdef ROUTER_SYNC_SOFT_RESET_EN
    exp_p0.push_back(s + 46);
`endif
    repeat (32) drive();
    {empty_2, empty_1, empty_0} = 3'b111;
    drive();
    check_pulses("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
